irq_ctrl: RTL

Memory-mapped interrupt controller on the processor data bus, directly downstream of the timer and the other polled devices. Watches up to 16 device status lines (e.g. timer ready bit), latches rising edges as pending interrupts, applies a software mask, and drives a single interrupt request to the processor with an acknowledge/end-of-interrupt handshake. Replaces busy-polling of device control registers.

---
 rtl/irq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching interrupt controller on the data bus.
// Pending/overrun, mask and in-service ID registers; single irq line.
module irq_ctrl #(
   parameter int               DBITS    = 32,
   parameter int               NSRC     = 4,
   parameter logic [DBITS-1:0] PENDBASE = 32'hF000_0200,
   parameter logic [DBITS-1:0] MASKBASE = 32'hF000_0204,
   parameter logic [DBITS-1:0] IDBASE   = 32'hF000_0208
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire  [DBITS-1:0] dbus,
   input  logic [DBITS-1:0] address,
   input  logic             wrtEn,
   input  logic [NSRC-1:0]  irqSrc,
   input  logic             irqAck,
   output logic             irq
);

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      INSERVICE
   } state_t;

   state_t            state;
   logic [NSRC-1:0]   pend;
   logic [NSRC-1:0]   ovr;
   logic [NSRC-1:0]   mask;
   logic [NSRC-1:0]   prev;
   logic [3:0]        is_id;

   logic              hit_pend;
   logic              hit_mask;
   logic              hit_id;
   logic              hit;
   logic              wr_pend;
   logic              wr_mask;
   logic              eoi;
   logic [NSRC-1:0]   edges;
   logic [NSRC-1:0]   pm;
   logic              req;
   logic [3:0]        sel;
   logic              ack_take;
   logic [NSRC-1:0]   ack_clr;
   logic [NSRC-1:0]   w1c_pend;
   logic [NSRC-1:0]   w1c_ovr;
   logic [DBITS-1:0]  rdata;
   logic              unused_bus;

   assign hit_pend = (address == PENDBASE);
   assign hit_mask = (address == MASKBASE);
   assign hit_id   = (address == IDBASE);
   assign hit      = hit_pend | hit_mask | hit_id;

   assign wr_pend  = wrtEn & hit_pend;
   assign wr_mask  = wrtEn & hit_mask;
   assign eoi      = wrtEn & hit_id & (state == INSERVICE);

   assign edges    = irqSrc & ~prev;
   assign pm       = pend & mask;
   assign req      = |pm;
   assign ack_take = (state == ASSERT) & req & irqAck;

   assign w1c_pend = wr_pend ? dbus[NSRC-1:0] : '0;
   assign w1c_ovr  = wr_pend ? dbus[16+NSRC-1:16] : '0;

   assign unused_bus = ^dbus;

   // lowest enabled pending index wins
   always_comb begin
      sel = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pm[i]) sel = 4'(i);
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NSRC; i++) begin
         ack_clr[i] = ack_take & (sel == 4'(i));
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         hit_pend: begin
            rdata[NSRC-1:0]    = pend;
            rdata[16+NSRC-1:16] = ovr;
         end
         hit_mask: rdata[NSRC-1:0] = mask;
         hit_id: begin
            rdata[31]  = (state == INSERVICE);
            rdata[3:0] = is_id;
         end
         default: ;
      endcase
   end

   assign dbus = (!wrtEn && hit) ? rdata : 'z;

   // an edge on an already-pending bit is an overrun, and set beats clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend  <= '0;
         ovr   <= '0;
         mask  <= '0;
         prev  <= '0;
         is_id <= '0;
         state <= IDLE;
         irq   <= 1'b0;
      end else begin
         prev <= irqSrc;
         pend <= (pend & ~w1c_pend & ~ack_clr) | (edges & ~ack_clr);
         ovr  <= (ovr & ~w1c_ovr) | (edges & pend);
         if (wr_mask) mask <= dbus[NSRC-1:0];
         unique case (state)
            IDLE: begin
               if (req) begin
                  state <= ASSERT;
                  irq   <= 1'b1;
               end else begin
                  irq   <= 1'b0;
               end
            end
            ASSERT: begin
               if (!req) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end else if (irqAck) begin
                  state <= INSERVICE;
                  is_id <= sel;
                  irq   <= 1'b0;
               end else begin
                  irq   <= 1'b1;
               end
            end
            INSERVICE: begin
               irq <= 1'b0;
               if (eoi) begin
                  state <= IDLE;
                  is_id <= '0;
               end
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule
